// File: rtl/cache_rd_arbiter_pkg.sv
// ============================================================================
// cache_rd_arbiter_pkg : shared types and constants for the cache read arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

package cache_rd_arbiter_pkg;

  typedef enum logic [1:0] {RD_IDLE, RD_ADDR, RD_DATA} rd_arb_state_t;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic [3:0]  len;
  } rd_req_t;

  // Legacy-compatible state encodings, tied to the enum values above
  localparam logic [1:0] ST_IDLE = RD_IDLE;
  localparam logic [1:0] ST_ADDR = RD_ADDR;
  localparam logic [1:0] ST_DATA = RD_DATA;

  localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  localparam logic OWNER_IC = 1'b0;
  localparam logic OWNER_DC = 1'b1;

endpackage

`default_nettype wire

// File: rtl/cache_rd_arbiter.sv
// ============================================================================
// cache_rd_arbiter : round-robin icache/dcache arbiter on one AXI AR/R channel
// Revision: 1.0
// ============================================================================
`default_nettype none

module cache_rd_arbiter
  import cache_rd_arbiter_pkg::*;
#(
  parameter logic [3:0] ICACHE_ID = 4'd0,
  parameter logic [3:0] DCACHE_ID = 4'd1
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        ic_req,
  input  logic [31:0] ic_addr,
  input  logic [3:0]  ic_len,
  output logic        ic_addr_ok,
  output logic        ic_rvalid,
  output logic        ic_rlast,
  output logic        ic_rerr,

  input  logic        dc_req,
  input  logic [31:0] dc_addr,
  input  logic [3:0]  dc_len,
  output logic        dc_addr_ok,
  output logic        dc_rvalid,
  output logic        dc_rlast,
  output logic        dc_rerr,

  output logic [31:0] rdata_o,

  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,

  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,

  output logic        proto_err
);

  logic [1:0]  state_q,      state_d;
  logic        owner_q,      owner_d;
  logic        last_owner_q, last_owner_d;
  rd_req_t     req_q,        req_d;
  logic [3:0]  arid_q,       arid_d;
  logic [3:0]  beat_cnt_q,   beat_cnt_d;
  logic        proto_err_q,  proto_err_d;

  logic        grant_dc;
  logic        ar_fire;
  logic        r_fire;
  logic        unused_rresp0;

  // Round-robin: on contention the previous owner yields.
  assign grant_dc = (ic_req && dc_req) ? ~last_owner_q : dc_req;

  assign arvalid = (state_q == ST_ADDR);
  assign rready  = (state_q == ST_DATA);
  assign ar_fire = arvalid && arready;
  assign r_fire  = rready && rvalid;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    req_d        = req_q;
    arid_d       = arid_q;
    beat_cnt_d   = beat_cnt_q;
    proto_err_d  = proto_err_q;

    case (state_q)
      ST_IDLE: begin
        if (ic_req || dc_req) begin
          owner_d = grant_dc;
          req_d   = grant_dc ? '{req: 1'b1, addr: dc_addr, len: dc_len}
                             : '{req: 1'b1, addr: ic_addr, len: ic_len};
          arid_d  = grant_dc ? DCACHE_ID : ICACHE_ID;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (arready) begin
          beat_cnt_d = 4'd0;
          state_d    = ST_DATA;
        end
      end
      ST_DATA: begin
        if (rvalid) begin
          beat_cnt_d = beat_cnt_q + 4'd1;
          if (rid != arid_q) proto_err_d = 1'b1;
          // A short or long burst is flagged, but rlast still closes it.
          if (rlast) begin
            if (beat_cnt_q != req_q.len) proto_err_d = 1'b1;
            last_owner_d = owner_q;
            state_d      = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWNER_IC;
      last_owner_q <= OWNER_DC;
      req_q        <= '0;
      arid_q       <= 4'd0;
      beat_cnt_q   <= 4'd0;
      proto_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      req_q        <= req_d;
      arid_q       <= arid_d;
      beat_cnt_q   <= beat_cnt_d;
      proto_err_q  <= proto_err_d;
    end
  end

  assign araddr    = req_q.addr;
  assign arlen     = {4'b0, req_q.len};
  assign arid      = arid_q;
  assign arsize    = AXI_SIZE_WORD;
  assign arburst   = AXI_BURST_INCR;
  assign proto_err = proto_err_q;

  assign ic_addr_ok = ar_fire && (owner_q == OWNER_IC);
  assign dc_addr_ok = ar_fire && (owner_q == OWNER_DC);
  assign ic_rvalid  = r_fire && (owner_q == OWNER_IC);
  assign dc_rvalid  = r_fire && (owner_q == OWNER_DC);
  assign ic_rlast   = ic_rvalid && rlast;
  assign dc_rlast   = dc_rvalid && rlast;
  assign ic_rerr    = ic_rvalid && rresp[1];
  assign dc_rerr    = dc_rvalid && rresp[1];
  assign rdata_o    = rdata;

  assign unused_rresp0 = rresp[0];

endmodule

`default_nettype wire

// File: tb/tb_cache_rd_arbiter.sv
// ============================================================================
// tb_cache_rd_arbiter : self-checking bench for cache_rd_arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_cache_rd_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        ic_req, dc_req;
  logic [31:0] ic_addr, dc_addr;
  logic [3:0]  ic_len, dc_len;
  logic        ic_addr_ok, ic_rvalid, ic_rlast, ic_rerr;
  logic        dc_addr_ok, dc_rvalid, dc_rlast, dc_rerr;
  logic [31:0] rdata_o;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic        proto_err;

  cache_rd_arbiter #(.ICACHE_ID(4'd0), .DCACHE_ID(4'd1)) dut (
    .clk(clk), .reset(reset),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_len(ic_len),
    .ic_addr_ok(ic_addr_ok), .ic_rvalid(ic_rvalid), .ic_rlast(ic_rlast), .ic_rerr(ic_rerr),
    .dc_req(dc_req), .dc_addr(dc_addr), .dc_len(dc_len),
    .dc_addr_ok(dc_addr_ok), .dc_rvalid(dc_rvalid), .dc_rlast(dc_rlast), .dc_rerr(dc_rerr),
    .rdata_o(rdata_o),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: pending requests per master, last winner, sticky protocol flag
  bit          pend_ic, pend_dc;
  logic [31:0] pic_addr, pdc_addr;
  logic [3:0]  pic_len, pdc_len;
  bit          m_last;
  bit          m_proto;

  typedef struct {
    bit new_ic;
    bit new_dc;
    bit exp_dc;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ic_req = 1'b0; dc_req = 1'b0;
    ic_addr = 32'd0; dc_addr = 32'd0; ic_len = 4'd0; dc_len = 4'd0;
    arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rid = 4'd0; rdata = 32'd0;
    pend_ic = 1'b0; pend_dc = 1'b0;
    tick();
    tick();
    #1;
    chk("rst_arvalid", 32'(arvalid), 32'd0);
    chk("rst_rready", 32'(rready), 32'd0);
    chk("rst_ar_fields", {arid, araddr[27:0]}, 32'd0);
    chk("rst_arlen", 32'(arlen), 32'd0);
    chk("rst_proto_err", 32'(proto_err), 32'd0);
    reset = 1'b0;
    m_last = 1'b1;
    m_proto = 1'b0;
  endtask

  task automatic raise(input bit want_ic, input bit want_dc);
    if (want_ic && !pend_ic) begin
      pend_ic = 1'b1;
      pic_addr = $urandom & 32'hffff_fffc;
      pic_len = 4'($urandom_range(0, 7));
    end
    if (want_dc && !pend_dc) begin
      pend_dc = 1'b1;
      pdc_addr = $urandom & 32'hffff_fffc;
      pdc_len = 4'($urandom_range(0, 7));
    end
  endtask

  // Called during an IDLE cycle; runs one full transaction for winner exp_w.
  task automatic run_txn(input bit exp_w, input int stall, input int err_beat,
                         input int nbeats_override, input bit use_base, input logic [31:0] base);
    logic [31:0] ea;
    logic [3:0]  el;
    logic [3:0]  eid;
    logic [31:0] d;
    logic [1:0]  own;
    int          nb;
    ic_req = pend_ic; ic_addr = pic_addr; ic_len = pic_len;
    dc_req = pend_dc; dc_addr = pdc_addr; dc_len = pdc_len;
    arready = 1'b0; rvalid = 1'b0;
    ea  = exp_w ? pdc_addr : pic_addr;
    el  = exp_w ? pdc_len : pic_len;
    eid = exp_w ? 4'd1 : 4'd0;
    own = exp_w ? 2'b01 : 2'b10;
    #1;
    chk("idle_arvalid", 32'(arvalid), 32'd0);
    tick();
    for (int s = 0; s < stall; s++) begin
      arready = 1'b0;
      rvalid = 1'($urandom_range(0, 1));
      rlast = 1'b1;
      #1;
      chk("stall_arvalid", 32'(arvalid), 32'd1);
      chk("stall_araddr", araddr, ea);
      chk("stall_arid", 32'(arid), 32'(eid));
      chk("stall_addr_ok", 32'({ic_addr_ok, dc_addr_ok}), 32'd0);
      chk("stall_stray_rvalid", 32'({ic_rvalid, dc_rvalid}), 32'd0);
      tick();
    end
    arready = 1'b1; rvalid = 1'b0; rlast = 1'b0;
    #1;
    chk("ar_arvalid", 32'(arvalid), 32'd1);
    chk("ar_araddr", araddr, ea);
    chk("ar_arid", 32'(arid), 32'(eid));
    chk("ar_arlen", 32'(arlen), 32'(el));
    chk("ar_size_burst", 32'({arsize, arburst}), 32'({3'b010, 2'b01}));
    chk("ar_addr_ok", 32'({ic_addr_ok, dc_addr_ok}), 32'(own));
    chk("ar_rready", 32'(rready), 32'd0);
    tick();
    arready = 1'b0;
    if (exp_w) begin pend_dc = 1'b0; dc_req = 1'b0; end
    else       begin pend_ic = 1'b0; ic_req = 1'b0; end
    nb = (nbeats_override > 0) ? nbeats_override : int'(el) + 1;
    for (int b = 0; b < nb; b++) begin
      if ($urandom_range(0, 2) == 0) begin
        rvalid = 1'b0;
        #1;
        chk("gap_rready", 32'(rready), 32'd1);
        chk("gap_rvalid", 32'({ic_rvalid, dc_rvalid}), 32'd0);
        tick();
      end
      d = use_base ? base + 32'(b) : $urandom;
      rvalid = 1'b1; rid = eid; rdata = d;
      rresp = (b == err_beat) ? 2'b10 : 2'b00;
      rlast = (b == nb - 1);
      #1;
      chk("beat_rvalid", 32'({ic_rvalid, dc_rvalid}), 32'(own));
      chk("beat_rlast", 32'({ic_rlast, dc_rlast}), (b == nb - 1) ? 32'(own) : 32'd0);
      chk("beat_rerr", 32'({ic_rerr, dc_rerr}), (b == err_beat) ? 32'(own) : 32'd0);
      chk("beat_rdata", rdata_o, d);
      tick();
    end
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
    if (nb != int'(el) + 1) m_proto = 1'b1;
    m_last = exp_w;
    #1;
    chk("end_proto_err", 32'(proto_err), 32'(m_proto));
    chk("end_rready", 32'(rready), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bit w;
    reset = 1'b1;

    // Basic icache line fetch with known data
    do_reset();
    pend_ic = 1'b1; pic_addr = 32'h1fc0_0000; pic_len = 4'd3;
    run_txn(1'b0, 0, -1, 0, 1'b1, 32'h0000_00a0);

    // Table of request patterns from reset with hand-derived winners
    tbl[0] = '{new_ic: 1'b1, new_dc: 1'b1, exp_dc: 1'b0};
    tbl[1] = '{new_ic: 1'b0, new_dc: 1'b0, exp_dc: 1'b1};
    tbl[2] = '{new_ic: 1'b1, new_dc: 1'b1, exp_dc: 1'b0};
    tbl[3] = '{new_ic: 1'b1, new_dc: 1'b0, exp_dc: 1'b1};
    tbl[4] = '{new_ic: 1'b0, new_dc: 1'b0, exp_dc: 1'b0};
    tbl[5] = '{new_ic: 1'b0, new_dc: 1'b1, exp_dc: 1'b1};
    tbl[6] = '{new_ic: 1'b1, new_dc: 1'b0, exp_dc: 1'b0};
    tbl[7] = '{new_ic: 1'b1, new_dc: 1'b1, exp_dc: 1'b1};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      raise(tbl[i].new_ic, tbl[i].new_dc);
      run_txn(tbl[i].exp_dc, i % 3, -1, 0, 1'b0, 32'd0);
    end

    // Both always requesting: strict alternation starting with icache
    do_reset();
    for (int i = 0; i < 8; i++) begin
      raise(1'b1, 1'b1);
      run_txn(1'((i % 2) != 0), 0, -1, 0, 1'b0, 32'd0);
    end

    // AR stall for 5 cycles on a single-beat dcache read
    do_reset();
    pend_dc = 1'b1; pdc_addr = 32'h8000_1000; pdc_len = 4'd0;
    run_txn(1'b1, 5, -1, 0, 1'b0, 32'd0);

    // Slave error on beat 2 of an icache line
    do_reset();
    pend_ic = 1'b1; pic_addr = 32'h0000_2000; pic_len = 4'd3;
    run_txn(1'b0, 0, 1, 0, 1'b0, 32'd0);

    // Reset during DATA after the first beat
    do_reset();
    ic_req = 1'b1; ic_addr = 32'h0000_4000; ic_len = 4'd3;
    tick();
    arready = 1'b1;
    tick();
    arready = 1'b0; ic_req = 1'b0;
    rvalid = 1'b1; rid = 4'd0; rlast = 1'b0; rdata = 32'h1234_5678;
    #1;
    chk("rstmid_beat1", 32'({ic_rvalid, dc_rvalid}), 32'd2);
    tick();
    rvalid = 1'b0;
    reset = 1'b1;
    tick();
    chk("rstmid_rready", 32'(rready), 32'd0);
    chk("rstmid_arvalid", 32'(arvalid), 32'd0);
    reset = 1'b0;
    m_last = 1'b1; m_proto = 1'b0;
    pend_ic = 1'b0; pend_dc = 1'b0;
    raise(1'b0, 1'b1);
    run_txn(1'b1, 1, -1, 0, 1'b0, 32'd0);

    // Early rlast flags proto_err; flag is sticky across the next transaction
    do_reset();
    pend_ic = 1'b1; pic_addr = 32'h0000_8000; pic_len = 4'd3;
    run_txn(1'b0, 0, -1, 2, 1'b0, 32'd0);
    raise(1'b0, 1'b1);
    run_txn(1'b1, 0, -1, 0, 1'b0, 32'd0);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 40; i++) begin
      raise(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if (!pend_ic && !pend_dc) raise(1'b1, 1'b0);
      w = (pend_ic && pend_dc) ? !m_last : pend_dc;
      run_txn(w, $urandom_range(0, 3), $urandom_range(0, 8), 0, 1'b0, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
